// File: rtl/sc_level_progress_counter.sv
// Frog-arrival counter and level sequencer that feeds the level state machine.
// Define SC_LEVEL_PROGRESS_ARRIVAL_FILTER_EN to qualify arrivals with a hold-time filter instead of a plain edge.
module sc_level_progress_counter #(
    parameter int TARGET        = 12,
    parameter int LEVEL_MAX     = 3,
    parameter int PAUSE_CYCLES  = 50_000_000,
    parameter int PAUSE_WIDTH   = 26,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       SC_LEVEL_STATEMACHINE_CLOCK_50,
    input  logic       SC_LEVEL_STATEMACHINE_RESET_InHigh,
    input  logic       SC_LEVEL_PROGRESS_Start_In,
    input  logic       SC_LEVEL_PROGRESS_Arrival_In,
    input  logic       SC_LEVEL_PROGRESS_LevelFinished_In,
    output logic [2:0] SC_LEVEL_PROGRESS_CurrentLevel_Out,
    output logic [4:0] SC_LEVEL_PROGRESS_LvlProgressCount_Out,
    output logic       SC_LEVEL_PROGRESS_LevelUp_Out,
    output logic       SC_LEVEL_PROGRESS_Playing_Out
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_PLAY     = 2'b01,
        ST_ADVANCE  = 2'b10,
        ST_GAMEOVER = 2'b11
    } state_t;

    localparam logic [4:0]             TARGET_C     = 5'(TARGET);
    localparam logic [2:0]             LEVEL_END_C  = 3'(LEVEL_MAX + 1);
    localparam logic [PAUSE_WIDTH-1:0] PAUSE_LOAD_C = PAUSE_WIDTH'(PAUSE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [2:0]             level_q, level_d;
    logic [4:0]             count_q, count_d;
    logic                   level_up_q, level_up_d;
    logic [PAUSE_WIDTH-1:0] pause_q, pause_d;
    logic                   prev_start_q;
    logic                   start_evt_s;
    logic                   arr_evt_s;
    logic [2:0]             level_inc_s;

    assign start_evt_s = SC_LEVEL_PROGRESS_Start_In & ~prev_start_q;
    assign level_inc_s = level_q + 3'd1;

`ifdef SC_LEVEL_PROGRESS_ARRIVAL_FILTER_EN
    localparam int            FW           = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] FILTER_MAX_C = FW'(FILTER_CYCLES);
    localparam logic [FW-1:0] FILTER_HIT_C = FW'(FILTER_CYCLES - 1);

    logic [FW-1:0] filt_q, filt_d;

    // Saturating run-length of consecutive high Arrival_In clocks; fires once per hold.
    always_comb begin
        filt_d = filt_q;
        if (!SC_LEVEL_PROGRESS_Arrival_In) begin
            filt_d = {FW{1'b0}};
        end else if (filt_q != FILTER_MAX_C) begin
            filt_d = filt_q + FW'(1);
        end else begin
            filt_d = filt_q;
        end
    end

    assign arr_evt_s = SC_LEVEL_PROGRESS_Arrival_In & (filt_q == FILTER_HIT_C);

    // Filter counter register.
    always_ff @(posedge SC_LEVEL_STATEMACHINE_CLOCK_50 or posedge SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
        if (SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
            filt_q <= {FW{1'b0}};
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    logic prev_arr_q;

    assign arr_evt_s = SC_LEVEL_PROGRESS_Arrival_In & ~prev_arr_q;

    // Previous arrival sample for rising-edge detection.
    always_ff @(posedge SC_LEVEL_STATEMACHINE_CLOCK_50 or posedge SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
        if (SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
            prev_arr_q <= 1'b0;
        end else begin
            prev_arr_q <= SC_LEVEL_PROGRESS_Arrival_In;
        end
    end
`endif

    // Next-state, level, progress count and pause countdown.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        count_d    = count_q;
        level_up_d = 1'b0;
        pause_d    = pause_q;
        case (state_q)
            ST_IDLE: begin
                level_d = 3'd0;
                count_d = 5'd0;
                if (start_evt_s) begin
                    level_d = 3'd1;
                    state_d = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // LevelFinished wins over a coincident arrival, which is dropped.
                if (SC_LEVEL_PROGRESS_LevelFinished_In) begin
                    state_d = ST_ADVANCE;
                    pause_d = PAUSE_LOAD_C;
                end else if (arr_evt_s && (count_q < TARGET_C)) begin
                    count_d = count_q + 5'd1;
                end else begin
                    count_d = count_q;
                end
            end
            ST_ADVANCE: begin
                if (pause_q == {PAUSE_WIDTH{1'b0}}) begin
                    level_d    = level_inc_s;
                    count_d    = 5'd0;
                    level_up_d = 1'b1;
                    if (level_inc_s >= LEVEL_END_C) begin
                        state_d = ST_GAMEOVER;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end else begin
                    pause_d = pause_q - PAUSE_WIDTH'(1);
                end
            end
            ST_GAMEOVER: begin
                level_d = LEVEL_END_C;
                count_d = 5'd0;
            end
            default: begin
                state_d = ST_IDLE;
                level_d = 3'd0;
                count_d = 5'd0;
                pause_d = {PAUSE_WIDTH{1'b0}};
            end
        endcase
    end

    // State, output and start-edge registers.
    always_ff @(posedge SC_LEVEL_STATEMACHINE_CLOCK_50 or posedge SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
        if (SC_LEVEL_STATEMACHINE_RESET_InHigh) begin
            state_q      <= ST_IDLE;
            level_q      <= 3'd0;
            count_q      <= 5'd0;
            level_up_q   <= 1'b0;
            pause_q      <= {PAUSE_WIDTH{1'b0}};
            prev_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            count_q      <= count_d;
            level_up_q   <= level_up_d;
            pause_q      <= pause_d;
            prev_start_q <= SC_LEVEL_PROGRESS_Start_In;
        end
    end

    assign SC_LEVEL_PROGRESS_CurrentLevel_Out     = level_q;
    assign SC_LEVEL_PROGRESS_LvlProgressCount_Out = count_q;
    assign SC_LEVEL_PROGRESS_LevelUp_Out          = level_up_q;
    assign SC_LEVEL_PROGRESS_Playing_Out          = (state_q == ST_PLAY);

endmodule

// File: tb/tb_sc_level_progress_counter.sv
// Randomized bench for sc_level_progress_counter against a game-level reference model.
module tb_sc_level_progress_counter;

    localparam int TARGET        = 12;
    localparam int LEVEL_MAX     = 3;
    localparam int PAUSE_CYCLES  = 4;
    localparam int FILTER_CYCLES = 4;
    localparam int M_IDLE = 0, M_PLAY = 1, M_ADV = 2, M_OVER = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       arr_i = 1'b0;
    logic       lf_i = 1'b0;
    logic [2:0] level_o;
    logic [4:0] count_o;
    logic       lu_o;
    logic       play_o;
    logic [9:0] dut_v;

    int checks = 0;
    int errors = 0;

    int m_mode, m_level, m_count, m_deadline, m_cyc, m_run;
    bit m_lu, m_prev_start;
`ifndef SC_LEVEL_PROGRESS_ARRIVAL_FILTER_EN
    bit m_prev_arr;
`endif
    bit lf_auto, lf_man;

    always #5 clk = ~clk;

    assign dut_v = {level_o, count_o, lu_o, play_o};

    sc_level_progress_counter #(
        .TARGET(TARGET), .LEVEL_MAX(LEVEL_MAX), .PAUSE_CYCLES(PAUSE_CYCLES),
        .PAUSE_WIDTH(26), .FILTER_CYCLES(FILTER_CYCLES)
    ) dut (
        .SC_LEVEL_STATEMACHINE_CLOCK_50        (clk),
        .SC_LEVEL_STATEMACHINE_RESET_InHigh    (rst),
        .SC_LEVEL_PROGRESS_Start_In            (start_i),
        .SC_LEVEL_PROGRESS_Arrival_In          (arr_i),
        .SC_LEVEL_PROGRESS_LevelFinished_In    (lf_i),
        .SC_LEVEL_PROGRESS_CurrentLevel_Out    (level_o),
        .SC_LEVEL_PROGRESS_LvlProgressCount_Out(count_o),
        .SC_LEVEL_PROGRESS_LevelUp_Out         (lu_o),
        .SC_LEVEL_PROGRESS_Playing_Out         (play_o)
    );

    task automatic model_reset();
        m_mode = M_IDLE; m_level = 0; m_count = 0; m_deadline = 0; m_run = 0;
        m_lu = 1'b0; m_prev_start = 1'b0;
`ifndef SC_LEVEL_PROGRESS_ARRIVAL_FILTER_EN
        m_prev_arr = 1'b0;
`endif
    endtask

    // Game rules: a level-up lands PAUSE_CYCLES clocks after LevelFinished is seen.
    task automatic model_step();
        bit s_evt, a_evt;
        s_evt = start_i && !m_prev_start;
`ifdef SC_LEVEL_PROGRESS_ARRIVAL_FILTER_EN
        m_run = arr_i ? m_run + 1 : 0;
        a_evt = (m_run == FILTER_CYCLES);
`else
        a_evt = arr_i && !m_prev_arr;
        m_prev_arr = arr_i;
`endif
        m_lu = 1'b0;
        case (m_mode)
            M_IDLE: if (s_evt) begin m_level = 1; m_mode = M_PLAY; end
            M_PLAY: begin
                if (lf_i) begin
                    m_mode = M_ADV; m_deadline = m_cyc + PAUSE_CYCLES;
                end else if (a_evt && m_count < TARGET) begin
                    m_count++;
                end
            end
            M_ADV: begin
                if (m_cyc == m_deadline) begin
                    m_level++; m_count = 0; m_lu = 1'b1;
                    m_mode = (m_level == LEVEL_MAX + 1) ? M_OVER : M_PLAY;
                end
            end
            default: ;
        endcase
        m_prev_start = start_i;
        m_cyc++;
    endtask

    function automatic logic [9:0] model_vec();
        return {3'(m_level), 5'(m_count), m_lu, (m_mode == M_PLAY)};
    endfunction

    task automatic tick();
        lf_i = lf_auto ? (m_count == TARGET) : lf_man;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        m_cyc = 0;
        repeat (2) @(posedge clk);
        #1;
        if (dut_v !== model_vec()) begin
            errors++;
            $display("FAIL reset_state got lvl/cnt/lu/pl=%0d/%0d/%0b/%0b want 0/0/0/0", level_o, count_o, lu_o, play_o);
        end
        checks++;
        rst = 1'b0;
        lf_auto = 1'b1;
        start_i = 1'b1; tick(); start_i = 1'b0; tick();
        for (int k = 0; k < 5; k++) begin
            arr_i = 1'b1; tick(); arr_i = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
            if (dut_v !== model_vec()) begin
                errors++;
                $display("FAIL reset_prep got lvl/cnt=%0d/%0d want %0d/%0d", level_o, count_o, m_level, m_count);
            end
            checks++;
        end
        #2 rst = 1'b1;
        #1;
        if ({level_o, count_o, lu_o, play_o} !== 10'd0) begin
            errors++;
            $display("FAIL reset_async got lvl/cnt/lu/pl=%0d/%0d/%0b/%0b want 0/0/0/0", level_o, count_o, lu_o, play_o);
        end
        checks++;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_start();
        repeat (3) tick();
        start_i = 1'b1; tick(); start_i = 1'b0;
        if (level_o !== 3'd1 || play_o !== 1'b1) begin
            errors++;
            $display("FAIL start_enter got lvl=%0d pl=%0b want 1/1", level_o, play_o);
        end
        checks++;
        repeat (2) tick();
        for (int k = 0; k < 3; k++) begin
            start_i = 1'($urandom_range(0, 1));
            tick();
            if (dut_v !== model_vec()) begin
                errors++;
                $display("FAIL start_repress got lvl=%0d pl=%0b want %0d/%0b", level_o, play_o, m_level, m_mode == M_PLAY);
            end
            checks++;
        end
        start_i = 1'b0;
        tick();
        if (level_o !== 3'd1) begin
            errors++;
            $display("FAIL start_hold got lvl=%0d want 1", level_o);
        end
        checks++;
    endtask

    task automatic test_count();
        int lvl_tick, lu_seen;
        lf_auto = 1'b0; lf_man = 1'b0;
        for (int k = 0; k < 14; k++) begin
            arr_i = 1'b1; tick(); arr_i = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                tick();
                if (dut_v !== model_vec()) begin
                    errors++;
                    $display("FAIL count_step got cnt=%0d want %0d", count_o, m_count);
                end
                checks++;
            end
        end
        if (count_o !== 5'd12) begin
            errors++;
            $display("FAIL count_saturate got %0d want 12", count_o);
        end
        checks++;
        lf_auto = 1'b1;
        lvl_tick = 0; lu_seen = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (lu_o === 1'b1) lu_seen++;
            if (level_o === 3'd2 && lvl_tick == 0) lvl_tick = i;
            if (dut_v !== model_vec()) begin
                errors++;
                $display("FAIL count_advance got lvl/cnt/lu=%0d/%0d/%0b want %0d/%0d/%0b", level_o, count_o, lu_o, m_level, m_count, m_lu);
            end
            checks++;
        end
        if (lvl_tick != 1 + PAUSE_CYCLES || lu_seen != 1 || count_o !== 5'd0) begin
            errors++;
            $display("FAIL count_latency got tick=%0d pulses=%0d cnt=%0d want %0d/1/0", lvl_tick, lu_seen, count_o, 1 + PAUSE_CYCLES);
        end
        checks++;
    endtask

    task automatic test_endgame();
        int budget;
        lf_auto = 1'b1;
        budget = 0;
        while (m_level < LEVEL_MAX + 1 && budget < 600) begin
            arr_i = 1'($urandom_range(0, 1));
            tick();
            budget++;
            if (dut_v !== model_vec()) begin
                errors++;
                $display("FAIL endgame_play got lvl/cnt/lu=%0d/%0d/%0b want %0d/%0d/%0b", level_o, count_o, lu_o, m_level, m_count, m_lu);
            end
            checks++;
        end
        if (budget >= 600 || level_o !== 3'd4 || play_o !== 1'b0) begin
            errors++;
            $display("FAIL endgame_reach got lvl=%0d pl=%0b cycles=%0d want 4/0", level_o, play_o, budget);
        end
        checks++;
        for (int k = 0; k < 30; k++) begin
            start_i = 1'($urandom_range(0, 1));
            arr_i   = 1'($urandom_range(0, 1));
            tick();
            if (level_o !== 3'd4 || count_o !== 5'd0 || lu_o !== 1'b0 || dut_v !== model_vec()) begin
                errors++;
                $display("FAIL endgame_hold got lvl/cnt/lu=%0d/%0d/%0b want 4/0/0", level_o, count_o, lu_o);
            end
            checks++;
        end
        start_i = 1'b0; arr_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        int c0;
        lf_auto = 1'b0; lf_man = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        start_i = 1'b1; tick(); start_i = 1'b0; tick();
        for (int k = 0; k < 7; k++) begin
            arr_i = 1'b1; tick(); arr_i = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        c0 = m_count;
        arr_i = 1'b1; lf_man = 1'b1; tick();
        if (count_o !== 5'(c0) || play_o !== 1'b0 || dut_v !== model_vec()) begin
            errors++;
            $display("FAIL simul_drop got cnt=%0d pl=%0b want %0d/0", count_o, play_o, c0);
        end
        checks++;
        lf_man = 1'b0;
        for (int k = 0; k < PAUSE_CYCLES - 1; k++) begin
            arr_i   = 1'($urandom_range(0, 1));
            start_i = 1'($urandom_range(0, 1));
            tick();
            if (count_o !== 5'(c0) || dut_v !== model_vec()) begin
                errors++;
                $display("FAIL simul_advance got lvl/cnt=%0d/%0d want %0d/%0d", level_o, count_o, m_level, c0);
            end
            checks++;
        end
        arr_i = 1'b0; start_i = 1'b0;
        tick();
        if (level_o !== 3'd2 || count_o !== 5'd0 || lu_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_levelup got lvl/cnt/lu=%0d/%0d/%0b want 2/0/1", level_o, count_o, lu_o);
        end
        checks++;
        lf_man = 1'b1; tick(); lf_man = 1'b0; tick();
        #2 rst = 1'b1;
        #1;
        if ({level_o, count_o, lu_o, play_o} !== 10'd0) begin
            errors++;
            $display("FAIL simul_abort got lvl/cnt/lu/pl=%0d/%0d/%0b/%0b want 0/0/0/0", level_o, count_o, lu_o, play_o);
        end
        checks++;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (dut_v !== model_vec()) begin
                errors++;
                $display("FAIL simul_idle got lvl/lu/pl=%0d/%0b/%0b want 0/0/0", level_o, lu_o, play_o);
            end
            checks++;
        end
    endtask

`ifdef SC_LEVEL_PROGRESS_ARRIVAL_FILTER_EN
    task automatic test_filter();
        int c0, hit;
        lf_auto = 1'b0; lf_man = 1'b0;
        start_i = 1'b1; tick(); start_i = 1'b0; tick();
        c0 = m_count;
        arr_i = 1'b1; repeat (3) tick(); arr_i = 1'b0; tick();
        if (count_o !== 5'(c0) || dut_v !== model_vec()) begin
            errors++;
            $display("FAIL filter_glitch got cnt=%0d want %0d", count_o, c0);
        end
        checks++;
        hit = 0;
        arr_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (count_o !== 5'(c0) && hit == 0) hit = i;
        end
        arr_i = 1'b0; tick();
        if (hit != FILTER_CYCLES || count_o !== 5'(c0 + 1) || dut_v !== model_vec()) begin
            errors++;
            $display("FAIL filter_hold got tick=%0d cnt=%0d want %0d/%0d", hit, count_o, FILTER_CYCLES, c0 + 1);
        end
        checks++;
        for (int k = 0; k < 40; k++) begin
            arr_i = 1'($urandom_range(0, 1));
            tick();
            if (dut_v !== model_vec()) begin
                errors++;
                $display("FAIL filter_random got cnt=%0d want %0d", count_o, m_count);
            end
            checks++;
        end
        arr_i = 1'b0;
    endtask
`endif

    initial begin
        lf_auto = 1'b1; lf_man = 1'b0;
        test_reset();
        test_start();
        test_count();
        test_endgame();
        test_simultaneous();
`ifdef SC_LEVEL_PROGRESS_ARRIVAL_FILTER_EN
        test_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
